// File: rtl/home_ctrl_pkg.sv
// Shared definitions for the home appliance controller: mode encodings,
// mode-selector FSM states and the millisecond-to-cycle helper.
package home_ctrl_pkg;

  localparam logic [1:0] MODE_WATCH     = 2'd0;
  localparam logic [1:0] MODE_STOPWATCH = 2'd1;
  localparam logic [1:0] MODE_MICROWAVE = 2'd2;
  localparam logic [1:0] MODE_FAN       = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HELD,
    PULSE,
    BLANK
  } mode_sel_state_t;

  // Clamped to one cycle so a zero-length interval never underflows a reload.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    int cyc;
    cyc = (clk_hz / 1000) * ms;
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/home_mode_sync2.sv
// Two-flop synchronizer for a bundle of independent asynchronous inputs.
module home_mode_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/home_mode_selector.sv
// Appliance mode selector: long btnC press cycles top_mode, short press is
// forwarded as a fixed-width pulse. Optional audible cue under MODE_SEL_BEEP_EN.
module home_mode_selector
  import home_ctrl_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int C_PULSE_MS    = 30,
  parameter int BLANK_MS      = 200,
  parameter int NUM_MODES     = 4,
  parameter int BEEP_MS       = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnC,
  input  logic       btnD,
  input  logic       busy,
  output logic [1:0] top_mode,
  output logic [3:0] fwd_btn,
  output logic       mode_changed,
  output logic       switch_reject,
  output logic       beep
);

  localparam int LONG_CYC  = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
  localparam int PULSE_CYC = ms_to_cycles(CLK_HZ, C_PULSE_MS);
  localparam int BLANK_CYC = ms_to_cycles(CLK_HZ, BLANK_MS);
  localparam int BEEP_CYC  = ms_to_cycles(CLK_HZ, BEEP_MS);
  localparam int MAX_CYC   = max_int(max_int(LONG_CYC, PULSE_CYC), max_int(BLANK_CYC, BEEP_CYC));
  // Counters are reloaded with N-1, so MAX_CYC-1 is the largest stored value.
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [1:0] LAST_MODE = 2'(NUM_MODES - 1);
  localparam logic [3:0] ULD_MASK  = 4'b1101;
  localparam logic [3:0] C_BIT     = 4'b0010;

  logic [3:0]       btn_raw;
  logic [3:0]       btn_sync;
  logic             c_sync;

  mode_sel_state_t  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       top_mode_reg, top_mode_next;
  logic             mode_changed_reg, mode_changed_next;
  logic             switch_reject_reg, switch_reject_next;

  assign btn_raw = {btnU, btnL, btnC, btnD};

  home_mode_sync2 #(
    .WIDTH (4)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign c_sync = btn_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      top_mode_reg      <= MODE_WATCH;
      mode_changed_reg  <= 1'b0;
      switch_reject_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      top_mode_reg      <= top_mode_next;
      mode_changed_reg  <= mode_changed_next;
      switch_reject_reg <= switch_reject_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    top_mode_next      = top_mode_reg;
    mode_changed_next  = 1'b0;
    switch_reject_next = 1'b0;
    fwd_btn            = 4'b0000;

    case (state_reg)
      IDLE: begin
        fwd_btn = btn_sync & ULD_MASK;
        if (c_sync) begin
          state_next = PRESS;
          cnt_next   = CNT_W'(LONG_CYC - 1);
        end
      end

      PRESS: begin
        fwd_btn = btn_sync & ULD_MASK;
        // Expiry is tested before release so a release on the last cycle is long.
        if (cnt_reg == '0) begin
          if (busy) begin
            switch_reject_next = 1'b1;
          end else begin
            top_mode_next     = (top_mode_reg == LAST_MODE) ? MODE_WATCH : top_mode_reg + 2'd1;
            mode_changed_next = 1'b1;
          end
          state_next = HELD;
        end else if (!c_sync) begin
          state_next = PULSE;
          cnt_next   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      HELD: begin
        if (!c_sync) begin
          state_next = BLANK;
          cnt_next   = CNT_W'(BLANK_CYC - 1);
        end
      end

      PULSE: begin
        fwd_btn = (btn_sync & ULD_MASK) | C_BIT;
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      BLANK: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign top_mode      = top_mode_reg;
  assign mode_changed  = mode_changed_reg;
  assign switch_reject = switch_reject_reg;

`ifdef MODE_SEL_BEEP_EN
  logic             beep_reg;
  logic [CNT_W-1:0] beep_cnt_reg;
  logic [1:0]       beep_left_reg;

  // beep_left_reg counts the remaining phase toggles: 0 for a single chirp,
  // 2 for the high-low-high pattern of a refused switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      beep_reg      <= 1'b0;
      beep_cnt_reg  <= '0;
      beep_left_reg <= 2'd0;
    end else if (mode_changed_reg) begin
      beep_reg      <= 1'b1;
      beep_cnt_reg  <= CNT_W'(BEEP_CYC - 1);
      beep_left_reg <= 2'd0;
    end else if (switch_reject_reg) begin
      beep_reg      <= 1'b1;
      beep_cnt_reg  <= CNT_W'(BEEP_CYC - 1);
      beep_left_reg <= 2'd2;
    end else if (beep_reg || (beep_left_reg != 2'd0)) begin
      if (beep_cnt_reg != '0) begin
        beep_cnt_reg <= beep_cnt_reg - 1'b1;
      end else if (beep_left_reg != 2'd0) begin
        beep_reg      <= ~beep_reg;
        beep_cnt_reg  <= CNT_W'(BEEP_CYC - 1);
        beep_left_reg <= beep_left_reg - 2'd1;
      end else begin
        beep_reg <= 1'b0;
      end
    end
  end

  assign beep = beep_reg;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_home_mode_selector.sv
// Directed bench for home_mode_selector at 1 ms = 1 cycle; NUM_MODES=3 so the wrap is visible.
module tb_home_mode_selector;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnU, btnL, btnC, btnD;
  logic       busy;
  logic [1:0] top_mode;
  logic [3:0] fwd_btn;
  logic       mode_changed;
  logic       switch_reject;
  logic       beep;

  int checks = 0;
  int errors = 0;

`ifdef MODE_SEL_BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  home_mode_selector #(
    .CLK_HZ        (1000),
    .LONG_PRESS_MS (10),
    .C_PULSE_MS    (3),
    .BLANK_MS      (5),
    .NUM_MODES     (3),
    .BEEP_MS       (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btnU          (btnU),
    .btnL          (btnL),
    .btnC          (btnC),
    .btnD          (btnD),
    .busy          (busy),
    .top_mode      (top_mode),
    .fwd_btn       (fwd_btn),
    .mode_changed  (mode_changed),
    .switch_reject (switch_reject),
    .beep          (beep)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at step %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // btnC held for 'hold' cycles (>= 10) starting at step 0; expiry lands on step 12,
  // outputs update on step 13, BLANK ends at idle_n.
  task automatic long_press(input int hold, input logic [1:0] m0, input logic [1:0] m1,
                            input logic bsy, input logic u_held);
    int         idle_n;
    logic [3:0] fwd_live;
    logic       exp_beep;
    idle_n   = (hold <= 11) ? 19 : hold + 8;
    fwd_live = u_held ? 4'b1000 : 4'b0000;
    busy     = bsy;
    btnU     = u_held;
    repeat (3) step();
    btnC = 1'b1;
    for (int n = 1; n <= idle_n + 2; n++) begin
      step();
      if (n == hold) btnC = 1'b0;
      exp_beep = BEEP_ON && (n == 14 || n == 15 || (bsy && (n == 18 || n == 19)));
      chk("top_mode", n, {6'd0, top_mode}, {6'd0, (n >= 13) ? m1 : m0});
      chk("fwd_btn", n, {4'd0, fwd_btn}, {4'd0, (n >= 13 && n < idle_n) ? 4'b0000 : fwd_live});
      chk("mode_changed", n, {7'd0, mode_changed}, {7'd0, (!bsy && n == 13)});
      chk("switch_reject", n, {7'd0, switch_reject}, {7'd0, (bsy && n == 13)});
      chk("beep", n, {7'd0, beep}, {7'd0, exp_beep});
    end
    $display("long press hold=%0d busy=%0b top_mode %0d -> %0d", hold, bsy, m0, top_mode);
    btnU = 1'b0;
    busy = 1'b0;
    repeat (3) step();
  endtask

  // btnC held for 'hold' cycles (< 10); forwarded C pulse spans steps hold+3..hold+5.
  task automatic short_press(input int hold, input logic [1:0] m);
    btnC = 1'b1;
    for (int n = 1; n <= hold + 8; n++) begin
      step();
      if (n == hold) btnC = 1'b0;
      chk("short fwd_btn", n, {4'd0, fwd_btn},
          {4'd0, (n >= hold + 3 && n <= hold + 5) ? 4'b0010 : 4'b0000});
      chk("short top_mode", n, {6'd0, top_mode}, {6'd0, m});
      chk("short mode_changed", n, {7'd0, mode_changed}, 8'd0);
    end
    $display("short press hold=%0d top_mode=%0d", hold, top_mode);
    repeat (2) step();
  endtask

  initial begin
    reset = 1'b1;
    btnU  = 1'b1;
    btnL  = 1'b1;
    btnC  = 1'b1;
    btnD  = 1'b1;
    busy  = 1'b0;

    repeat (3) step();
    chk("reset top_mode", 0, {6'd0, top_mode}, 8'd0);
    chk("reset fwd_btn", 0, {4'd0, fwd_btn}, 8'd0);
    chk("reset mode_changed", 0, {7'd0, mode_changed}, 8'd0);
    chk("reset switch_reject", 0, {7'd0, switch_reject}, 8'd0);
    chk("reset beep", 0, {7'd0, beep}, 8'd0);
    $display("reset held 3 cycles with all buttons high");

    reset = 1'b0;
    btnU  = 1'b0;
    btnL  = 1'b0;
    btnC  = 1'b0;
    btnD  = 1'b0;
    repeat (4) step();
    chk("post-reset fwd_btn", 0, {4'd0, fwd_btn}, 8'd0);

    short_press(4, 2'd0);

    long_press(15, 2'd0, 2'd1, 1'b0, 1'b1);
    long_press(10, 2'd1, 2'd2, 1'b0, 1'b0);
    long_press(15, 2'd2, 2'd0, 1'b0, 1'b0);

    short_press(9, 2'd0);

    long_press(12, 2'd0, 2'd0, 1'b1, 1'b0);

    long_press(15, 2'd0, 2'd1, 1'b0, 1'b0);
    btnC = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 4) btnC = 1'b0;
    end
    chk("pulse before reset", 8, {4'd0, fwd_btn}, 8'h02);
    reset = 1'b1;
    step();
    chk("reset in pulse fwd_btn", 9, {4'd0, fwd_btn}, 8'd0);
    chk("reset in pulse top_mode", 9, {6'd0, top_mode}, 8'd0);
    chk("reset in pulse beep", 9, {7'd0, beep}, 8'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("after reset fwd_btn", 12, {4'd0, fwd_btn}, 8'd0);
    $display("reset during pulse top_mode=%0d fwd_btn=%0h", top_mode, fwd_btn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
